// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if -- one request/response channel of the DRAM arbiter.
//
// The same bundle serves both the requester side (m0, m1) and the DRAM
// controller side (d).  The requester/arbiter that issues the request
// uses the master modport; the side that completes it uses slave.
//
//   valid  master->slave  request pending, held until ready
//   addr   master->slave  byte address, stable while valid
//   wmask  master->slave  1 = write, 0 = read
//   wdata  master->slave  write line
//   ready  slave->master  one-cycle completion pulse
//   rdata  slave->master  read line
interface dram_arbiter_if;
    logic         valid;
    logic [31:0]  addr;
    logic         wmask;
    logic [127:0] wdata;
    logic         ready;
    logic [127:0] rdata;

    modport master (
        output valid, addr, wmask, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wmask, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter -- two-port arbiter in front of a single DRAM controller.
//
// Ports:
//   clk   rising-edge clock
//   rstn  synchronous, active-low reset
//   m0    requester port 0 (slave side); favoured by default
//   m1    requester port 1 (slave side); protected from starvation
//   d     DRAM controller request/response (master side)
//
// One transaction is in flight at a time: IDLE picks a winner and
// registers its request onto d, BUSY holds the request until d.ready,
// DONE pulses the winner's ready for one cycle.
module dram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4  // max consecutive port-0 grants while port 1 waits (1..15)
) (
    input  logic           clk,
    input  logic           rstn,
    dram_arbiter_if.slave  m0,
    dram_arbiter_if.slave  m1,
    dram_arbiter_if.master d
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       grant;       // 0 = port 0 owns the transaction, 1 = port 1
    logic [3:0] starve_cnt;  // consecutive port-0 grants with port 1 waiting
    logic       any_valid;
    logic       pick1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        any_valid  = m0.valid | m1.valid;
        // Port 1 wins when alone, or when port 0 has used up its quota.
        pick1      = m1.valid & (~m0.valid | (starve_cnt == LIMIT));
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = BUSY;
            BUSY:    if (d.ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Completion pulse is simply "in DONE" qualified by the owner, so the
    // two ready outputs can never be high together.
    assign m0.ready = (state == DONE) & ~grant;
    assign m1.ready = (state == DONE) &  grant;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            grant      <= 1'b0;
            starve_cnt <= '0;
            d.valid    <= 1'b0;
            d.addr     <= '0;
            d.wmask    <= 1'b0;
            d.wdata    <= '0;
            m0.rdata   <= '0;
            m1.rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant   <= pick1;
                        d.valid <= 1'b1;
                        d.addr  <= pick1 ? m1.addr  : m0.addr;
                        d.wmask <= pick1 ? m1.wmask : m0.wmask;
                        d.wdata <= pick1 ? m1.wdata : m0.wdata;
                        // Only a port-0 win over a waiting port 1 counts; the
                        // limit check in pick1 keeps this from passing LIMIT.
                        if (pick1 || !m1.valid) begin
                            starve_cnt <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                BUSY: begin
                    // d.addr/wmask/wdata are left untouched for the whole
                    // transaction; the controller may sample them late.
                    if (d.ready) begin
                        d.valid <= 1'b0;
                        if (!d.wmask) begin
                            if (grant) begin
                                m1.rdata <= d.rdata;
                            end else begin
                                m0.rdata <= d.rdata;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter -- scoreboard bench for dram_arbiter.
//
// The stimulus process plays both requesters and the DRAM controller.
// A transaction-level model decides, from the arbitration rules, which
// request the arbiter must forward next and what each requester must
// receive; expectations are queued with the cycle they are due on.  A
// separate monitor pops and compares whenever the DUT presents d.valid
// or a ready pulse.
module tb_dram_arbiter;

    localparam int unsigned LIMIT = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dram_arbiter_if m0_if ();
    dram_arbiter_if m1_if ();
    dram_arbiter_if d_if ();

    dram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .m0   (m0_if),
        .m1   (m1_if),
        .d    (d_if)
    );

    // ---------------- bench-driven signals ----------------
    logic         rq_valid [2];
    logic [31:0]  rq_addr  [2];
    logic         rq_wmask [2];
    logic [127:0] rq_wdata [2];
    logic         ctl_ready;
    logic [127:0] ctl_rdata;

    assign m0_if.valid = rq_valid[0];
    assign m0_if.addr  = rq_addr[0];
    assign m0_if.wmask = rq_wmask[0];
    assign m0_if.wdata = rq_wdata[0];
    assign m1_if.valid = rq_valid[1];
    assign m1_if.addr  = rq_addr[1];
    assign m1_if.wmask = rq_wmask[1];
    assign m1_if.wdata = rq_wdata[1];
    assign d_if.ready  = ctl_ready;
    assign d_if.rdata  = ctl_rdata;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0]  addr;
        logic         wmask;
        logic [127:0] wdata;
        int           due;
    } dreq_t;

    typedef struct packed {
        logic [127:0] rdata;
        int           due;
    } rsp_t;

    dreq_t dq[$];
    rsp_t  rsp_q0[$];
    rsp_t  rsp_q1[$];
    int    order_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic port_ready(int p);
        return (p == 0) ? m0_if.ready : m1_if.ready;
    endfunction

    // ---------------- reference model state ----------------
    bit           pend [2];
    bit           stage_v [2];
    logic [31:0]  stage_addr [2];
    logic         stage_wmask [2];
    logic [127:0] stage_wdata [2];
    int           req_prob = 0;
    int           fixed_delay = -1;
    bit           rdata_force_v = 0;
    logic [127:0] rdata_force;
    bit           spurious = 0;

    bit           mfree = 1;     // next edge is an IDLE evaluation
    int           free_cnt = 0;
    bit           ctl_active = 0;
    int           d_wait = 0;
    int           gport = 0;
    logic         g_wmask = 1'b0;
    int           starve = 0;
    logic [127:0] last_rdata [2];

    function automatic bit model_idle();
        return mfree && !ctl_active && !pend[0] && !pend[1] && !stage_v[0] && !stage_v[1];
    endfunction

    task automatic push_rsp(int p, logic [127:0] rd, int due);
        rsp_t r;
        r.rdata = rd;
        r.due   = due;
        if (p == 0) rsp_q0.push_back(r);
        else        rsp_q1.push_back(r);
    endtask

    // One bench cycle: requesters, model bookkeeping, controller, arbitration.
    task automatic cycle();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (pend[p] && port_ready(p)) begin
                pend[p]     = 0;
                rq_valid[p] = 1'b0;
            end else if (!pend[p]) begin
                if (stage_v[p]) begin
                    rq_addr[p]  = stage_addr[p];
                    rq_wmask[p] = stage_wmask[p];
                    rq_wdata[p] = stage_wdata[p];
                    stage_v[p]  = 0;
                    pend[p]     = 1;
                    rq_valid[p] = 1'b1;
                end else if ($urandom_range(99) < req_prob) begin
                    rq_addr[p]  = $urandom();
                    rq_wmask[p] = 1'($urandom_range(1));
                    rq_wdata[p] = rand128();
                    pend[p]     = 1;
                    rq_valid[p] = 1'b1;
                end else begin
                    // idle port: wiggle its fields, the arbiter must not care
                    rq_addr[p]  = $urandom();
                    rq_wmask[p] = 1'($urandom_range(1));
                    rq_wdata[p] = rand128();
                end
            end
        end

        if (free_cnt > 0) begin
            free_cnt--;
            if (free_cnt == 0) mfree = 1;
        end

        ctl_ready = 1'b0;
        if (ctl_active) begin
            if (d_wait == 0) begin
                ctl_ready = 1'b1;
                ctl_rdata = rdata_force_v ? rdata_force : rand128();
                rdata_force_v = 0;
                if (!g_wmask) last_rdata[gport] = ctl_rdata;
                push_rsp(gport, last_rdata[gport], ncyc + 1);
                ctl_active = 0;
                free_cnt   = 2;   // ready shows next cycle, arbitration the one after
            end else begin
                d_wait--;
            end
        end else if (spurious && mfree) begin
            ctl_ready = 1'b1;
            ctl_rdata = rand128();
            spurious  = 0;
        end

        if (mfree && (pend[0] || pend[1])) begin
            dreq_t e;
            int w;
            w = (pend[1] && (!pend[0] || starve == int'(LIMIT))) ? 1 : 0;
            if (w == 1 || !pend[1]) starve = 0;
            else                    starve = starve + 1;
            e.addr  = rq_addr[w];
            e.wmask = rq_wmask[w];
            e.wdata = rq_wdata[w];
            e.due   = ncyc + 1;
            dq.push_back(e);
            gport      = w;
            g_wmask    = rq_wmask[w];
            ctl_active = 1;
            d_wait     = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(3));
            fixed_delay = -1;
            mfree      = 0;
        end
    endtask

    task automatic wait_idle(int limit);
        int k = 0;
        while (!model_idle() && k < limit) begin
            cycle();
            k++;
        end
        check("idle_reached", 128'(model_idle()), 128'd1);
    endtask

    task automatic stage(int p, logic [31:0] a, logic wm, logic [127:0] wd);
        stage_v[p]     = 1;
        stage_addr[p]  = a;
        stage_wmask[p] = wm;
        stage_wdata[p] = wd;
    endtask

    // Reset for one clock edge in the middle of whatever is in flight.
    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; stage_v[p] = 0; rq_valid[p] = 1'b0; last_rdata[p] = '0;
        end
        ctl_ready = 1'b0; ctl_active = 0; mfree = 1; free_cnt = 0; starve = 0;
        dq.delete(); rsp_q0.delete(); rsp_q1.delete();
        @(negedge clk);
        check("rst_d_valid",  128'(d_if.valid),  128'd0);
        check("rst_d_addr",   128'(d_if.addr),   128'd0);
        check("rst_d_wmask",  128'(d_if.wmask),  128'd0);
        check("rst_d_wdata",  d_if.wdata,        128'd0);
        check("rst_m0_ready", 128'(m0_if.ready), 128'd0);
        check("rst_m1_ready", 128'(m1_if.ready), 128'd0);
        check("rst_m0_rdata", m0_if.rdata,       128'd0);
        check("rst_m1_rdata", m1_if.rdata,       128'd0);
        rstn = 1'b1;
    endtask

    // ---------------- monitor ----------------
    task automatic check_rsp(int p, logic [127:0] rd);
        rsp_t r;
        bit   empty;
        empty = (p == 0) ? (rsp_q0.size() == 0) : (rsp_q1.size() == 0);
        if (empty) begin
            check(p == 0 ? "m0_ready_unexpected" : "m1_ready_unexpected", 128'd1, 128'd0);
        end else begin
            r = (p == 0) ? rsp_q0.pop_front() : rsp_q1.pop_front();
            check(p == 0 ? "m0_rdata" : "m1_rdata", rd, r.rdata);
            check(p == 0 ? "m0_ready_latency" : "m1_ready_latency", 128'(ncyc), 128'(r.due));
        end
        order_log.push_back(p);
    endtask

    initial begin
        dreq_t cur;
        bit    prev = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev = 0;
            end else begin
                if (d_if.valid && !prev) begin
                    if (dq.size() == 0) begin
                        check("d_valid_unexpected", 128'd1, 128'd0);
                        cur = '{addr: d_if.addr, wmask: d_if.wmask, wdata: d_if.wdata, due: ncyc};
                    end else begin
                        cur = dq.pop_front();
                    end
                    check("d_valid_latency", 128'(ncyc), 128'(cur.due));
                end
                if (d_if.valid) begin
                    check("d_addr",  128'(d_if.addr),  128'(cur.addr));
                    check("d_wmask", 128'(d_if.wmask), 128'(cur.wmask));
                    check("d_wdata", d_if.wdata,       cur.wdata);
                end
                if (m0_if.ready || m1_if.ready)
                    check("ready_exclusive", 128'(m0_if.ready & m1_if.ready), 128'd0);
                if (m0_if.ready) check_rsp(0, m0_if.rdata);
                if (m1_if.ready) check_rsp(1, m1_if.rdata);
                prev = d_if.valid;
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int base;
        int k;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; stage_v[p] = 0; last_rdata[p] = '0;
            rq_valid[p] = 1'b0; rq_addr[p] = '0; rq_wmask[p] = 1'b0; rq_wdata[p] = '0;
        end
        ctl_ready = 1'b0;
        ctl_rdata = '0;

        // reset values
        repeat (2) @(negedge clk);
        check("reset_d_valid",  128'(d_if.valid),  128'd0);
        check("reset_d_addr",   128'(d_if.addr),   128'd0);
        check("reset_d_wdata",  d_if.wdata,        128'd0);
        check("reset_m0_ready", 128'(m0_if.ready), 128'd0);
        check("reset_m1_ready", 128'(m1_if.ready), 128'd0);
        check("reset_m0_rdata", m0_if.rdata,       128'd0);
        rstn = 1'b1;

        // single port-0 read
        stage(0, 32'h0000_1000, 1'b0, '0);
        fixed_delay   = 0;
        rdata_force_v = 1;
        rdata_force   = {16{8'hA5}};
        wait_idle(50);
        check("single_read_m0_rdata", m0_if.rdata, {16{8'hA5}});
        check("single_read_m1_rdata", m1_if.rdata, 128'd0);

        // simultaneous port-0 read and port-1 write
        base = order_log.size();
        stage(0, $urandom(), 1'b0, rand128());
        stage(1, $urandom(), 1'b1, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
        wait_idle(50);
        check("both_first_port",  128'(order_log.size() > base     ? order_log[base]     : -1), 128'd0);
        check("both_second_port", 128'(order_log.size() > base + 1 ? order_log[base + 1] : -1), 128'd1);
        check("write_m1_rdata_hold", m1_if.rdata, 128'd0);

        // both ports continuously requesting: port 1 gets every (LIMIT+1)th grant
        base = order_log.size();
        req_prob = 100;
        k = 0;
        while (order_log.size() < base + 2 * (LIMIT + 1) && k < 400) begin
            cycle();
            k++;
        end
        req_prob = 0;
        wait_idle(100);
        for (int i = 0; i < 2 * int'(LIMIT + 1); i++) begin
            check("starve_order",
                  128'(order_log.size() > base + i ? order_log[base + i] : -1),
                  128'((i % int'(LIMIT + 1)) == int'(LIMIT) ? 1 : 0));
        end

        // long controller latency, then a stray d_ready while idle
        stage(0, $urandom(), 1'b0, rand128());
        fixed_delay = 20;
        wait_idle(60);
        spurious = 1;
        repeat (4) cycle();
        check("spurious_m0_rdata", m0_if.rdata, last_rdata[0]);
        check("spurious_m1_rdata", m1_if.rdata, last_rdata[1]);

        // reset in the middle of a transaction, then a fresh request
        stage(0, $urandom(), 1'b0, rand128());
        fixed_delay = 30;
        repeat (5) cycle();
        pulse_reset();
        repeat (3) cycle();
        stage(1, $urandom(), 1'b0, rand128());
        wait_idle(50);
        check("post_reset_m1_rdata", m1_if.rdata, last_rdata[1]);

        // random traffic
        req_prob = 40;
        repeat (400) cycle();
        req_prob = 0;
        wait_idle(200);
        repeat (3) cycle();

        check("dq_drained",  128'(dq.size()),     128'd0);
        check("rsp0_drained", 128'(rsp_q0.size()), 128'd0);
        check("rsp1_drained", 128'(rsp_q1.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Parameters
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive port-0 grants while port 1 waits (legal range 1..15).

Interface
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have ports m0_valid/m1_valid  input  1  request pending, held until that port's ready.
REQ-005 SHALL have ports m0_addr/m1_addr  input  32  byte address, stable while valid.
REQ-006 SHALL have ports m0_wmask/m1_wmask  input  1  1=write, 0=read.
REQ-007 SHALL have ports m0_wdata/m1_wdata  input  128  write line.
REQ-008 SHALL have ports m0_ready/m1_ready  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports m0_rdata/m1_rdata  output  128  read line, held until that port's next completion.
REQ-010 SHALL have ports d_valid  output  1, d_addr  output  32, d_wmask  output  1, d_wdata  output  128: the DRAM controller request.
REQ-011 SHALL have ports d_ready  input  1  (one-cycle completion pulse) and d_rdata  input  128  (read line): the DRAM controller response.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 In IDLE with any mX_valid high, SHALL select a winner, register its addr/wmask/wdata onto d_addr/d_wmask/d_wdata, set d_valid=1 next cycle, and enter BUSY.
REQ-014 Arbitration SHALL be: port 0 wins by default; port 1 wins if only port 1 is valid, or if both are valid and starve_cnt==STARVE_LIMIT.
REQ-015 starve_cnt (4 bits) SHALL increment on a port-0 grant while m1_valid is high, and clear on a port-1 grant or a port-0 grant with m1_valid low; it never exceeds STARVE_LIMIT.
REQ-016 In BUSY, d_valid, d_addr, d_wmask and d_wdata SHALL stay constant, because the controller samples addr in more than one cycle.
REQ-017 On d_ready in BUSY, SHALL clear d_valid next cycle, capture d_rdata into the granted port's rdata register when d_wmask=0 (hold it on writes), and enter DONE.
REQ-018 In DONE, SHALL pulse the granted port's mX_ready for exactly one cycle and return to IDLE; mX_valid is not evaluated in DONE.
REQ-019 Latency SHALL be: request seen in IDLE at cycle N gives d_valid=1 at N+1; d_ready at cycle M gives mX_ready=1 at M+1 and earliest next grant evaluated at M+2.
REQ-020 d_ready outside BUSY SHALL be ignored.
REQ-021 The non-granted port's valid SHALL remain pending without side effects; both ready outputs are never high in the same cycle.
REQ-022 A requester dropping valid before its ready is illegal; behaviour is undefined, and the grant still completes.

Reset
REQ-023 While rstn=0 at a clock edge, SHALL set state=IDLE, d_valid=0, m0_ready=m1_ready=0, starve_cnt=0, d_addr=0, d_wmask=0, d_wdata=0, and m0_rdata=m1_rdata=0.
REQ-024 Reset mid-BUSY SHALL abandon the grant and issue no ready; rstn is asserted with the controller's system reset so that no stale d_ready arrives in BUSY.

Verification
REQ-025 Single port-0 read to addr 0x0000_1000 with d_ready one cycle and d_rdata=0xA5..A5 -> d_valid rises 1 cycle after m0_valid; d_addr=0x1000, d_wmask=0; m0_ready pulses 1 cycle after d_ready; m0_rdata=0xA5..A5; m1_ready stays 0.
REQ-026 Simultaneous port-0 read and port-1 write (wdata=0x0123..EF) from IDLE -> port 0 served first, then port 1 with d_wmask=1 and d_wdata=0x0123..EF; m1_rdata unchanged.
REQ-027 Port 0 continuously valid and port 1 valid throughout, STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,...; starve_cnt returns to 0 after the port-1 grant.
REQ-028 d_valid held for 20 cycles before d_ready, while the test changes m1 inputs -> d_addr/d_wmask/d_wdata constant; one ready pulse only; a spurious d_ready injected in IDLE is ignored.
REQ-029 rstn low for 1 cycle during BUSY -> next cycle d_valid=0, state IDLE, no mX_ready; a fresh request after release is served normally.
